fastram_bridge: RTL and testbench
=================================

Name: fastram_bridge

Overview:
- Sits directly downstream of the core's fastram port (fastram_address/datatoram/we/ce/datafromram).
- Converts per-fast_clk CPU accesses into a level req/ack transaction to the SDRAM controller.
- Holds cpu_wait high while a transaction is outstanding.
- Returns read data as a registered byte, stable between completed reads.

Parameters:
- ADDR_W, 23, width of the byte address (bank[6:0] & addr[15:0]).
- TIMEOUT, 64, clk_sys cycles to wait for sd_ack before aborting. Legal range 2..1023.
- ABORT_DATA, 8'hFF, byte returned on a read that times out.

Ports:
- clk_sys  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- fast_clk  in  1  one-cycle access strobe from the clock divider (1 in 8 clk_sys).
- fastram_ce  in  1  CPU access targets fast RAM.
- fastram_we  in  1  1 = write, 0 = read.
- fastram_address  in  ADDR_W  byte address.
- fastram_datatoram  in  8  write data.
- fastram_datafromram  out  8  registered read data to the core.
- cpu_wait  out  1  stall request to the core.
- sd_req  out  1  level request to the SDRAM controller.
- sd_we  out  1  write qualifier, valid while sd_req is high.
- sd_addr  out  ADDR_W  address, valid while sd_req is high.
- sd_din  out  8  write data, valid while sd_req is high.
- sd_ack  in  1  one-cycle completion pulse.
- sd_dout  in  8  read data, valid in the sd_ack cycle.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset values: all outputs 0; state IDLE; timer 0.
- State IDLE:
  - On fast_clk & fastram_ce, capture address, data and we into sd_addr/sd_din/sd_we.
  - On the next edge: sd_req=1, cpu_wait=1, state REQ.
  - fast_clk without fastram_ce: no action.
- State REQ:
  - sd_req, sd_addr, sd_din and sd_we are held constant.
  - Timer increments each cycle.
  - sd_ack=1 (read): latch sd_dout into fastram_datafromram, drop sd_req and cpu_wait on the same edge, go to DONE.
  - sd_ack=1 (write): fastram_datafromram is unchanged; same exits as a read.
  - Timer reaches TIMEOUT-1 without sd_ack: drop sd_req and cpu_wait, set err=1. A read loads ABORT_DATA; a write is discarded. Go to DONE.
  - sd_ack and timeout in the same cycle: sd_ack wins and err is not set.
- State DONE:
  - Lasts one cycle; timer cleared; back to IDLE.
  - A fast_clk & fastram_ce arriving in DONE is captured as if in IDLE (no access is lost).
- fast_clk while in REQ: ignored. The core is stalled and must not issue.
- Latency: request-to-data is sd_ack cycle + 1. With an immediate ack, cpu_wait is high for exactly 1 cycle.
- sd_ack while in IDLE or DONE: ignored.
- err: cleared only by reset.
- Reset asserted mid-REQ: all outputs return to 0 immediately (asynchronously). No pending transaction survives.
- Address is passed through unmodified. No width arithmetic beyond the TIMEOUT counter, which is sized to hold TIMEOUT-1.

Optional Feature:
- Macro: FASTRAM_RCACHE_EN.
- When defined, a one-entry read cache holds {valid, addr, data}:
  - The cache is loaded on each successful read ack.
  - A read that hits the valid cache completes in IDLE: fastram_datafromram is loaded on the next edge, with no sd_req and no cpu_wait.
  - A write whose address equals the cached address updates the cached data and still issues a normal SDRAM write.
  - A timeout or reset invalidates the cache.
- When not defined, every access goes to SDRAM; no cache logic exists.

Test Plan:
- Read, ack 3 cycles after sd_req rises with sd_dout=8'h5A: cpu_wait high 3 cycles, fastram_datafromram=8'h5A one edge after ack, sd_req low after ack.
- Write of 8'hC3 to address 23'h01_2345: sd_addr=23'h012345, sd_din=8'hC3, sd_we=1 until ack; fastram_datafromram unchanged.
- TIMEOUT=8, read with no ack: sd_req high 8 cycles then low, fastram_datafromram=8'hFF, err=1 and stays 1 through further accesses.
- Ack and timeout in the same cycle: sd_dout captured, err remains 0.
- Back-to-back accesses with immediate ack, next fast_clk landing in DONE: second request issued, both complete in order.
- With FASTRAM_RCACHE_EN, two reads of address 23'h000400:
  - First read issues sd_req; second read has no sd_req and cpu_wait stays 0, returning the same data.
  - An intervening write of 8'h11 to that address makes the next read return 8'h11 without sd_req.

Source files
------------

// File: rtl/fastram_bridge.sv
// rtl/fastram_bridge.sv - fastram port to SDRAM req/ack bridge; optional one-entry read cache via FASTRAM_RCACHE_EN
module fastram_bridge #(
  parameter int          ADDR_W     = 23,
  parameter int          TIMEOUT    = 64,
  parameter logic [7:0]  ABORT_DATA = 8'hFF
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              fast_clk,
  input  logic              fastram_ce,
  input  logic              fastram_we,
  input  logic [ADDR_W-1:0] fastram_address,
  input  logic [7:0]        fastram_datatoram,
  output logic [7:0]        fastram_datafromram,
  output logic              cpu_wait,
  output logic              sd_req,
  output logic              sd_we,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [7:0]        sd_din,
  input  logic              sd_ack,
  input  logic [7:0]        sd_dout,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // timer only ever has to hold TIMEOUT-1
  localparam int            TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  state_t        state;
  logic [TW-1:0] timer;
  logic          start;

  assign start = fast_clk & fastram_ce;

`ifdef FASTRAM_RCACHE_EN
  logic              c_valid;
  logic [ADDR_W-1:0] c_addr;
  logic [7:0]        c_data;
  logic              addr_match;
  logic              rd_hit;

  // cache lookup against the address the core is presenting right now
  always_comb begin
    addr_match = c_valid && (c_addr == fastram_address);
    rd_hit     = addr_match && !fastram_we;
  end
`endif

  // transaction sequencer: IDLE/DONE accept a new access, REQ waits for ack or timeout
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      timer               <= '0;
      sd_req              <= 1'b0;
      sd_we               <= 1'b0;
      sd_addr             <= '0;
      sd_din              <= '0;
      cpu_wait            <= 1'b0;
      fastram_datafromram <= '0;
      err                 <= 1'b0;
`ifdef FASTRAM_RCACHE_EN
      c_valid             <= 1'b0;
      c_addr              <= '0;
      c_data              <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          // DONE behaves like IDLE so an access issued right after a completion is not lost
          timer <= '0;
          state <= IDLE;
          if (start) begin
`ifdef FASTRAM_RCACHE_EN
            if (rd_hit) begin
              fastram_datafromram <= c_data;
            end else begin
              if (fastram_we && addr_match) c_data <= fastram_datatoram;
              sd_addr  <= fastram_address;
              sd_din   <= fastram_datatoram;
              sd_we    <= fastram_we;
              sd_req   <= 1'b1;
              cpu_wait <= 1'b1;
              state    <= REQ;
            end
`else
            sd_addr  <= fastram_address;
            sd_din   <= fastram_datatoram;
            sd_we    <= fastram_we;
            sd_req   <= 1'b1;
            cpu_wait <= 1'b1;
            state    <= REQ;
`endif
          end
        end
        REQ: begin
          // ack takes priority over a timeout landing in the same cycle
          if (sd_ack) begin
            sd_req   <= 1'b0;
            cpu_wait <= 1'b0;
            timer    <= '0;
            state    <= DONE;
            if (!sd_we) begin
              fastram_datafromram <= sd_dout;
`ifdef FASTRAM_RCACHE_EN
              c_valid <= 1'b1;
              c_addr  <= sd_addr;
              c_data  <= sd_dout;
`endif
            end
          end else if (timer == TLAST) begin
            sd_req   <= 1'b0;
            cpu_wait <= 1'b0;
            err      <= 1'b1;
            timer    <= '0;
            state    <= DONE;
            if (!sd_we) fastram_datafromram <= ABORT_DATA;
`ifdef FASTRAM_RCACHE_EN
            c_valid <= 1'b0;
`endif
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fastram_bridge.sv
// tb/tb_fastram_bridge.sv - directed self-checking bench for fastram_bridge (TIMEOUT=8)
module tb_fastram_bridge;

  logic        clk_sys;
  logic        reset;
  logic        fast_clk;
  logic        fastram_ce;
  logic        fastram_we;
  logic [22:0] fastram_address;
  logic [7:0]  fastram_datatoram;
  logic [7:0]  fastram_datafromram;
  logic        cpu_wait;
  logic        sd_req;
  logic        sd_we;
  logic [22:0] sd_addr;
  logic [7:0]  sd_din;
  logic        sd_ack;
  logic [7:0]  sd_dout;
  logic        err;

  int vectors     = 0;
  int miscompares = 0;

  fastram_bridge #(
    .ADDR_W     (23),
    .TIMEOUT    (8),
    .ABORT_DATA (8'hFF)
  ) dut (
    .clk_sys             (clk_sys),
    .reset               (reset),
    .fast_clk            (fast_clk),
    .fastram_ce          (fastram_ce),
    .fastram_we          (fastram_we),
    .fastram_address     (fastram_address),
    .fastram_datatoram   (fastram_datatoram),
    .fastram_datafromram (fastram_datafromram),
    .cpu_wait            (cpu_wait),
    .sd_req              (sd_req),
    .sd_we               (sd_we),
    .sd_addr             (sd_addr),
    .sd_din              (sd_din),
    .sd_ack              (sd_ack),
    .sd_dout             (sd_dout),
    .err                 (err)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a posedge. Issues one access; ack_at = REQ cycle (1 = immediate) in
  // which sd_ack is driven, 0 = never. Returns cpu_wait high cycles, sd_req right after
  // the capture edge, and whether the SDRAM side stayed constant while stalled.
  task automatic do_access(input logic we, input logic [22:0] a, input logic [7:0] d,
                           input int ack_at, input logic [7:0] dout,
                           output int wait_cyc, output logic req0, output logic held_ok);
    fast_clk          = 1'b1;
    fastram_ce        = 1'b1;
    fastram_we        = we;
    fastram_address   = a;
    fastram_datatoram = d;
    @(posedge clk_sys); #1;
    fast_clk          = 1'b0;
    fastram_ce        = 1'b0;
    fastram_address   = ~a;
    fastram_datatoram = ~d;
    req0     = sd_req;
    wait_cyc = 0;
    held_ok  = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (cpu_wait !== 1'b1) break;
      wait_cyc++;
      if (sd_req !== 1'b1 || sd_addr !== a || sd_din !== d || sd_we !== we) held_ok = 1'b0;
      if (k == ack_at) begin
        sd_ack  = 1'b1;
        sd_dout = dout;
      end
      @(posedge clk_sys); #1;
      sd_ack  = 1'b0;
      sd_dout = 8'h00;
    end
  endtask

  initial begin
    int   w;
    logic r0;
    logic ok;

    reset = 1'b1; fast_clk = 1'b0; fastram_ce = 1'b0; fastram_we = 1'b0;
    fastram_address = '0; fastram_datatoram = '0; sd_ack = 1'b0; sd_dout = '0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_sd_req",   32'(sd_req), 32'h0);
    chk("rst_cpu_wait", 32'(cpu_wait), 32'h0);
    chk("rst_data",     32'(fastram_datafromram), 32'h0);
    chk("rst_err",      32'(err), 32'h0);
    chk("rst_sd_addr",  32'(sd_addr), 32'h0);
    chk("rst_sd_din_we", 32'({sd_din, sd_we}), 32'h0);
    reset = 1'b0;
    @(posedge clk_sys); #1;

    // read, ack in third REQ cycle
    do_access(1'b0, 23'h000010, 8'h00, 3, 8'h5A, w, r0, ok);
    chk("rd_req_rise", 32'(r0), 32'h1);
    chk("rd_wait3",    32'(w), 32'd3);
    chk("rd_held",     32'(ok), 32'h1);
    chk("rd_data",     32'(fastram_datafromram), 32'h5A);
    chk("rd_req_drop", 32'(sd_req), 32'h0);
    chk("rd_err",      32'(err), 32'h0);

    // write, data must not reach fastram_datafromram
    do_access(1'b1, 23'h012345, 8'hC3, 2, 8'hEE, w, r0, ok);
    chk("wr_wait2", 32'(w), 32'd2);
    chk("wr_held",  32'(ok), 32'h1);
    chk("wr_data",  32'(fastram_datafromram), 32'h5A);

    // idle noise: fast_clk without ce, stray ack
    @(posedge clk_sys); #1;
    fast_clk = 1'b1; fastram_address = 23'h000777;
    @(posedge clk_sys); #1;
    fast_clk = 1'b0;
    chk("noce_req",  32'(sd_req), 32'h0);
    chk("noce_wait", 32'(cpu_wait), 32'h0);
    sd_ack = 1'b1; sd_dout = 8'h77;
    @(posedge clk_sys); #1;
    sd_ack = 1'b0; sd_dout = 8'h00;
    chk("idle_ack_data", 32'(fastram_datafromram), 32'h5A);
    chk("idle_ack_req",  32'(sd_req), 32'h0);

    // ack in the same cycle as the timeout
    do_access(1'b0, 23'h000020, 8'h00, 8, 8'h3C, w, r0, ok);
    chk("race_wait8", 32'(w), 32'd8);
    chk("race_data",  32'(fastram_datafromram), 32'h3C);
    chk("race_err",   32'(err), 32'h0);

    // back-to-back immediate acks, second issued during DONE
    do_access(1'b0, 23'h000030, 8'h00, 1, 8'hA1, w, r0, ok);
    chk("b2b1_wait1", 32'(w), 32'd1);
    chk("b2b1_data",  32'(fastram_datafromram), 32'hA1);
    do_access(1'b0, 23'h000031, 8'h00, 1, 8'hB2, w, r0, ok);
    chk("b2b2_wait1", 32'(w), 32'd1);
    chk("b2b2_held",  32'(ok), 32'h1);
    chk("b2b2_data",  32'(fastram_datafromram), 32'hB2);

    // read timeout
    do_access(1'b0, 23'h000040, 8'h00, 0, 8'h00, w, r0, ok);
    chk("to_rd_wait8", 32'(w), 32'd8);
    chk("to_rd_data",  32'(fastram_datafromram), 32'hFF);
    chk("to_rd_err",   32'(err), 32'h1);
    chk("to_rd_req",   32'(sd_req), 32'h0);

    // write timeout is discarded
    do_access(1'b1, 23'h000041, 8'h55, 0, 8'h00, w, r0, ok);
    chk("to_wr_wait8", 32'(w), 32'd8);
    chk("to_wr_data",  32'(fastram_datafromram), 32'hFF);

    // err stays set through a good access
    do_access(1'b0, 23'h000050, 8'h00, 2, 8'h66, w, r0, ok);
    chk("sticky_data", 32'(fastram_datafromram), 32'h66);
    chk("sticky_err",  32'(err), 32'h1);

    // repeated read of one address
    do_access(1'b0, 23'h000400, 8'h00, 2, 8'h9D, w, r0, ok);
    chk("c1_req",  32'(r0), 32'h1);
    chk("c1_data", 32'(fastram_datafromram), 32'h9D);
`ifdef FASTRAM_RCACHE_EN
    do_access(1'b0, 23'h000400, 8'h00, 2, 8'h00, w, r0, ok);
    chk("c2_hit_req",  32'(r0), 32'h0);
    chk("c2_hit_wait", 32'(w), 32'd0);
    chk("c2_hit_data", 32'(fastram_datafromram), 32'h9D);
    do_access(1'b1, 23'h000400, 8'h11, 1, 8'h00, w, r0, ok);
    chk("cw_req",  32'(r0), 32'h1);
    chk("cw_wait", 32'(w), 32'd1);
    do_access(1'b0, 23'h000400, 8'h00, 2, 8'h00, w, r0, ok);
    chk("c3_hit_req",  32'(r0), 32'h0);
    chk("c3_hit_data", 32'(fastram_datafromram), 32'h11);
`else
    do_access(1'b0, 23'h000400, 8'h00, 2, 8'h9E, w, r0, ok);
    chk("c2_req",  32'(r0), 32'h1);
    chk("c2_wait", 32'(w), 32'd2);
    chk("c2_data", 32'(fastram_datafromram), 32'h9E);
`endif

    // reset in the middle of REQ
    @(posedge clk_sys); #1;
    fast_clk = 1'b1; fastram_ce = 1'b1; fastram_we = 1'b0; fastram_address = 23'h000400;
    @(posedge clk_sys); #1;
    fast_clk = 1'b0; fastram_ce = 1'b0;
    chk("mid_req_up", 32'(sd_req), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_req",  32'(sd_req), 32'h0);
    chk("mid_rst_wait", 32'(cpu_wait), 32'h0);
    chk("mid_rst_err",  32'(err), 32'h0);
    chk("mid_rst_data", 32'(fastram_datafromram), 32'h0);
    @(posedge clk_sys); #1;
    reset = 1'b0;
    @(posedge clk_sys); #1;

    // after reset nothing is cached
    do_access(1'b0, 23'h000400, 8'h00, 1, 8'h12, w, r0, ok);
    chk("post_rst_req",  32'(r0), 32'h1);
    chk("post_rst_data", 32'(fastram_datafromram), 32'h12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
